// File: rtl/gradient_port_arbiter_pkg.sv
// Shared types and the round-robin pick helper used by the gradient BRAM port arbiters.
package sift_arb_pkg;

  localparam int ARB_MAX_REQ = 4;
  localparam int ARB_PTR_W   = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Id field is sized for the largest supported requester count; unused bits stay zero.
  typedef struct packed {
    logic                   valid;
    logic [ARB_MAX_REQ-1:0] id;
  } resp_tag_t;

  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
    input logic [ARB_MAX_REQ-1:0] req,
    input logic [ARB_PTR_W-1:0]   ptr,
    input logic [2:0]             num
  );
    logic [ARB_MAX_REQ-1:0] grant;
    logic [2:0]             idx;
    logic                   found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= num) idx = idx - num;
      if ((3'(k) < num) && !found && req[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/gradient_port_arbiter_if.sv
// Requester-side handshake plus BRAM read port of one gradient BRAM arbiter.
interface gradient_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic                          bram_en;
  logic [DATA_WIDTH-1:0]         bram_dout;
  logic                          busy;

  modport master (
    output req_valid, req_addr, req_lock, bram_dout,
    input  req_ready, resp_valid, resp_data, bram_addr, bram_en, busy
  );

  modport slave (
    input  req_valid, req_addr, req_lock, bram_dout,
    output req_ready, resp_valid, resp_data, bram_addr, bram_en, busy
  );
endinterface

// File: rtl/gradient_port_arbiter_read_tag_pipe.sv
// Fixed-latency shift register carrying {valid, requester id} alongside a BRAM read.
module read_tag_pipe
  import sift_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst_in,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o,
  output logic      busy_o
);

  resp_tag_t stage_q [DEPTH];

  // Shift tags one stage per clock; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/gradient_port_arbiter.sv
// Round-robin read-port arbiter with burst lock in front of one gradient BRAM;
// a tag pipeline routes each read result back to the requester that issued it.
module gradient_port_arbiter
  import sift_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input logic                    clk,
  input logic                    rst_in,
  gradient_port_arbiter_if.slave bus
);

  arb_state_t             state_q, state_d;
  logic [ARB_PTR_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [ARB_MAX_REQ-1:0] valid_vec, lock_vec, grant_vec;
  logic [ARB_PTR_W-1:0]   win_idx;
  logic [ADDR_WIDTH-1:0]  win_addr, bram_addr_q;
  logic                   win_lock, accept, bram_en_q, tags_busy;
  resp_tag_t              tag_in, tag_out;

  function automatic logic [ARB_PTR_W-1:0] next_idx(input logic [ARB_PTR_W-1:0] i);
    return (i == ARB_PTR_W'(NUM_REQ - 1)) ? 2'd0 : i + 2'd1;
  endfunction

  // Grant: round-robin search when idle, owner-only while locked; never looks at addresses.
  always_comb begin
    valid_vec                 = '0;
    lock_vec                  = '0;
    grant_vec                 = '0;
    valid_vec[NUM_REQ-1:0]    = bus.req_valid;
    lock_vec[NUM_REQ-1:0]     = bus.req_lock;
    if (state_q == ARB_IDLE) begin
      grant_vec = rr_pick(valid_vec, rr_ptr_q, 3'(NUM_REQ));
    end else begin
      grant_vec[owner_q] = valid_vec[owner_q];
    end
  end

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx  = win_idx | (grant_vec[i] ? ARB_PTR_W'(i) : 2'd0);
      win_addr = win_addr | ({ADDR_WIDTH{grant_vec[i]}} & bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign accept   = |grant_vec;
  assign win_lock = |(grant_vec & lock_vec);

  // Lock state machine; the pointer only advances on unlocked beats or when a lock ends.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && win_lock) begin
          state_d = ARB_LOCKED;
          owner_d = win_idx;
        end else if (accept) begin
          rr_ptr_d = next_idx(win_idx);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ARB_LOCKED: begin
        if ((accept && !win_lock) || (!valid_vec[owner_q] && !lock_vec[owner_q])) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_idx(owner_q);
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      bram_en_q <= accept;
      if (accept) bram_addr_q <= win_addr;
    end
  end

  assign tag_in = {accept, grant_vec};

  read_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_in (rst_in),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .busy_o (tags_busy)
  );

  assign bus.req_ready  = grant_vec[NUM_REQ-1:0];
  assign bus.resp_valid = tag_out.valid ? tag_out.id[NUM_REQ-1:0] : '0;
  assign bus.resp_data  = bus.bram_dout;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.busy       = (state_q == ARB_LOCKED) | tags_busy;

endmodule

// File: tb/tb_gradient_port_arbiter.sv
// Directed and randomized bench for gradient_port_arbiter against a queue-based reference model.
module tb_gradient_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gradient_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  gradient_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  gradient_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2))
    dut_a (.clk(clk), .rst_in(rst), .bus(ifa.slave));
  gradient_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1))
    dut_b (.clk(clk), .rst_in(rst), .bus(ifb.slave));

  // BRAM contents: 0x0A5 reads back as 8'hF3.
  function automatic logic [7:0] bram_f(input logic [11:0] a);
    return a[7:0] ^ 8'h56 ^ {a[11:8], 4'h0};
  endfunction

  logic [7:0] da0, da1, db0;
  always @(posedge clk) begin
    if (ifa.bram_en) da0 <= bram_f(ifa.bram_addr);
    da1 <= da0;
    if (ifb.bram_en) db0 <= bram_f(ifb.bram_addr);
  end
  assign ifa.bram_dout = da1;
  assign ifb.bram_dout = db0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          m_locked;
  int          m_owner, m_ptr;
  bit          m_en;
  logic [11:0] m_addr;
  typedef struct { int due; int id; logic [11:0] addr; } resp_t;
  resp_t rq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [3:0] vec, input int i);
    logic [1:0] s;
    s = i[1:0];
    return vec[s];
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_en     = 1'b0;
    m_addr   = '0;
    rq.delete();
  endtask

  // One clock of requester A: drive, compare at the falling edge, advance the model.
  task automatic step_a(input logic [1:0] v, input logic [1:0] l, input logic [11:0] a0, input logic [11:0] a1);
    int          g;
    logic [1:0]  exp_ready, exp_resp;
    logic [11:0] ga;
    ifa.req_valid = v;
    ifa.req_lock  = l;
    ifa.req_addr  = {a1, a0};
    @(negedge clk);
    g = -1;
    if (m_locked) begin
      if (bit_of(4'(v), m_owner)) g = m_owner;
    end else begin
      for (int k = 0; k < 2; k++)
        if (g < 0 && bit_of(4'(v), (m_ptr + k) % 2)) g = (m_ptr + k) % 2;
    end
    exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
    chk("ready", 32'(ifa.req_ready), 32'(exp_ready));
    chk("bram_en", 32'(ifa.bram_en), 32'(m_en));
    chk("bram_addr", 32'(ifa.bram_addr), 32'(m_addr));
    chk("busy", 32'(ifa.busy), 32'(m_locked || (rq.size() > 0)));
    exp_resp = 2'b00;
    if (rq.size() > 0 && rq[0].due == cyc) exp_resp = 2'(1 << rq[0].id);
    chk("resp_valid", 32'(ifa.resp_valid), 32'(exp_resp));
    if (exp_resp != 2'b00) begin
      chk("resp_data", 32'(ifa.resp_data), 32'(bram_f(rq[0].addr)));
      void'(rq.pop_front());
    end
    if (g >= 0) begin
      ga = (g == 1) ? a1 : a0;
      rq.push_back('{cyc + 3, g, ga});
      m_en   = 1'b1;
      m_addr = ga;
    end else begin
      m_en = 1'b0;
    end
    if (!m_locked) begin
      if (g >= 0) begin
        if (bit_of(4'(l), g)) begin
          m_locked = 1'b1;
          m_owner  = g;
        end else begin
          m_ptr = (g + 1) % 2;
        end
      end
    end else if ((g >= 0 && !bit_of(4'(l), g)) || (g < 0 && !bit_of(4'(l), m_owner))) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % 2;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(2'b00, 2'b00, 12'h000, 12'h000);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ifa.req_valid = 2'b11;
    ifa.req_lock  = 2'b00;
    ifa.req_addr  = '0;
    ifb.req_valid = 3'b000;
    ifb.req_lock  = 3'b000;
    ifb.req_addr  = '0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_bram_en", 32'(ifa.bram_en), 32'd0);
    chk("rst_bram_addr", 32'(ifa.bram_addr), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_ready", 32'(ifa.req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    ifa.req_valid = 2'b00;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    ifa.req_valid = '0;
    ifa.req_lock  = '0;
    ifa.req_addr  = '0;
    ifb.req_valid = '0;
    ifb.req_lock  = '0;
    ifb.req_addr  = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Single read.
    do_reset();
    step_a(2'b01, 2'b00, 12'h0A5, 12'h000);
    idle_a(5);

    // Contention right after reset: 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) step_a(2'b11, 2'b00, 12'h010 + 12'(k), 12'h020 + 12'(k));
    idle_a(4);

    // Burst lock by requester 1 while requester 0 keeps asking.
    do_reset();
    step_a(2'b01, 2'b00, 12'h050, 12'h000);
    for (int k = 0; k < 4; k++) step_a(2'b11, {(k < 3), 1'b0}, 12'h060, 12'd100 + 12'(k));
    step_a(2'b01, 2'b00, 12'h061, 12'h000);
    idle_a(4);

    // Lock abandoned by its owner.
    do_reset();
    step_a(2'b01, 2'b01, 12'h070, 12'h000);
    step_a(2'b10, 2'b00, 12'h000, 12'h080);
    step_a(2'b10, 2'b00, 12'h000, 12'h081);
    idle_a(4);

    // Reset with reads in flight.
    do_reset();
    for (int k = 0; k < 3; k++) step_a(2'b11, 2'b00, 12'h090 + 12'(k), 12'h0A0 + 12'(k));
    do_reset();
    idle_a(5);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++)
      step_a(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom));
    idle_a(5);

    // Three requesters, latency 1: pointer wraps 2 -> 0, response at N+2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ifb.req_valid = (k < 4) ? 3'b111 : 3'b000;
      ifb.req_lock  = 3'b000;
      ifb.req_addr  = {12'h202, 12'h201, 12'h200};
      @(negedge clk);
      chk("b_ready", 32'(ifb.req_ready), (k < 4) ? (32'd1 << (k % 3)) : 32'd0);
      chk("b_resp_valid", 32'(ifb.resp_valid), (k >= 2) ? (32'd1 << ((k - 2) % 3)) : 32'd0);
      if (k >= 2) chk("b_resp_data", 32'(ifb.resp_data), 32'(bram_f(12'h200 + 12'((k - 2) % 3))));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
